chan_demux: RTL and testbench

//  Corner-turn buffer for channelizer output: takes frame-interleaved samples (one per channel, channel
//  0..NUM_CHANS-1 in order, s_tlast on last channel) and emits per-channel packets of PKT_LEN samples.

---
 rtl/chan_demux_pkg.sv | 16 +
 rtl/chan_demux_if.sv | 12 +
 rtl/chan_demux_pingpong.sv | 42 ++++
 rtl/chan_demux.sv | 220 ++++++++++++++++++++++
 tb/tb_chan_demux.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/chan_demux_pkg.sv
// Shared definitions for the channelizer corner-turn buffer: settings offsets
// and the readout state encoding.
package chan_demux_pkg;

    localparam int SR_MASK_LO_OFS = 0;
    localparam int SR_MASK_HI_OFS = 1;
    localparam int DATA_W         = 32;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_SCAN,
        RD_READ,
        RD_RELEASE
    } rd_state_t;

endpackage

// File: rtl/chan_demux_if.sv
// AXI-stream style sample bus used on both sides of the corner-turn buffer.
interface chan_demux_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, tlast, tvalid, input  tready);
    modport slave  (input  tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/chan_demux_pingpong.sv
// Two-bank sample store: simple dual-port RAM with registered read, plus one
// full flag per bank that the writer sets and the reader clears.
module chan_demux_pingpong #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              ce_clk,
    input  logic              ce_rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              set_full,
    input  logic              set_bank,
    input  logic              clr_full,
    input  logic              clr_bank,
    output logic [1:0]        full
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [1:0]        set_vec;
    logic [1:0]        clr_vec;

    // NOTE: the array has no reset so it maps onto block RAM; the full flags guard stale contents.
    always_ff @(posedge ce_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    assign set_vec = {set_full &  set_bank, set_full & ~set_bank};
    assign clr_vec = {clr_full &  clr_bank, clr_full & ~clr_bank};

    // Banks are independent, so one can fill while the other releases.
    always_ff @(posedge ce_clk) begin
        if (ce_rst) full <= '0;
        else        full <= (full | set_vec) & ~clr_vec;
    end

endmodule

// File: rtl/chan_demux.sv
// Corner-turn buffer: frame-interleaved channel samples in, channel-major
// packets of PKT_LEN samples out, with a per-channel enable mask.
module chan_demux
    import chan_demux_pkg::*;
#(
    parameter int NUM_CHANS = 64,
    parameter int PKT_LEN   = 32,
    parameter int SR_BASE   = 128
) (
    input  logic                         ce_clk,
    input  logic                         ce_rst,
    input  logic                         set_stb,
    input  logic [7:0]                   set_addr,
    input  logic [31:0]                  set_data,
    chan_demux_if.slave                  s_axis,
    chan_demux_if.master                 m_axis,
    output logic [$clog2(NUM_CHANS)-1:0] m_chan,
    output logic                         sync_err
);
    localparam int CHAN_W  = $clog2(NUM_CHANS);
    localparam int FRAME_W = $clog2(PKT_LEN);
    localparam int ADDR_W  = 1 + FRAME_W + CHAN_W;
    localparam logic [7:0] SR_LO = 8'(SR_BASE + SR_MASK_LO_OFS);
    localparam logic [7:0] SR_HI = 8'(SR_BASE + SR_MASK_HI_OFS);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [CHAN_W-1:0] chan;
    } beat_t;

    logic [NUM_CHANS-1:0] mask, mask_q;
    logic [1:0]           full;
    logic                 rst_done, wr_bank;
    logic [FRAME_W-1:0]   frame_cnt;
    logic [CHAN_W-1:0]    chan_cnt;
    logic                 wr_fire, wr_bad, wr_keep, bank_done, chan_last, frame_last;

    rd_state_t            state, state_d;
    logic                 rd_bank, issue, release_bank, rd_chan_last, rd_frame_last;
    logic [CHAN_W-1:0]    rd_chan;
    logic [FRAME_W-1:0]   rd_frame;
    logic [DATA_W-1:0]    ram_rdata;
    logic                 rd_pend, pend_last, pop, space;
    logic [CHAN_W-1:0]    pend_chan;
    logic [1:0]           sk_cnt;
    logic [2:0]           occ;
    beat_t                sk0, sk1, push_beat;

    // Channels 0..31 live in the low word, 32..63 in the high word.
    always_ff @(posedge ce_clk) begin
        if (ce_rst) mask <= '1;
        else if (set_stb) begin
            for (int i = 0; i < NUM_CHANS; i++) begin
                if ((i < 32) ? (set_addr == SR_LO) : (set_addr == SR_HI))
                    mask[i] <= set_data[i % 32];
            end
        end
    end

    assign chan_last  = (chan_cnt == CHAN_W'(NUM_CHANS - 1));
    assign frame_last = (frame_cnt == FRAME_W'(PKT_LEN - 1));
    assign s_axis.tready = rst_done & ~full[wr_bank];
    assign wr_fire   = s_axis.tvalid & s_axis.tready;
    assign wr_bad    = wr_fire & (s_axis.tlast ^ chan_last);
    assign wr_keep   = wr_fire & ~wr_bad;
    assign bank_done = wr_keep & chan_last & frame_last;

    // A misaligned beat is dropped and the partial bank restarts at channel 0.
    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            rst_done  <= 1'b0;
            wr_bank   <= 1'b0;
            frame_cnt <= '0;
            chan_cnt  <= '0;
            sync_err  <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            sync_err <= wr_bad;
            if (wr_bad) begin
                frame_cnt <= '0;
                chan_cnt  <= '0;
            end else if (wr_keep) begin
                chan_cnt <= chan_cnt + CHAN_W'(1);
                if (chan_last) begin
                    frame_cnt <= frame_cnt + FRAME_W'(1);
                    if (frame_last) wr_bank <= ~wr_bank;
                end
            end
        end
    end

    chan_demux_pingpong #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_banks (
        .ce_clk   (ce_clk),
        .ce_rst   (ce_rst),
        .wr_en    (wr_keep),
        .wr_addr  ({wr_bank, frame_cnt, chan_cnt}),
        .wr_data  (s_axis.tdata),
        .rd_en    (issue),
        .rd_addr  ({rd_bank, rd_frame, rd_chan}),
        .rd_data  (ram_rdata),
        .set_full (bank_done),
        .set_bank (wr_bank),
        .clr_full (release_bank),
        .clr_bank (rd_bank)
        , .full   (full)
    );

    // Issue a read only if the skid can absorb it even when the consumer stalls.
    assign pop   = m_axis.tvalid & m_axis.tready;
    assign occ   = 3'(sk_cnt) + 3'(rd_pend) - 3'(pop);
    assign space = (occ <= 3'd1);
    assign rd_chan_last  = (rd_chan == CHAN_W'(NUM_CHANS - 1));
    assign rd_frame_last = (rd_frame == FRAME_W'(PKT_LEN - 1));

    always_ff @(posedge ce_clk) begin
        if (ce_rst) state <= RD_IDLE;
        else        state <= state_d;
    end

    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        state_d      = state;
        issue        = 1'b0;
        release_bank = 1'b0;
        case (state)
            RD_IDLE:    if (full[rd_bank]) state_d = RD_SCAN;
            RD_SCAN: begin
                if (mask_q[rd_chan])   state_d = RD_READ;
                else if (rd_chan_last) state_d = RD_RELEASE;
            end
            RD_READ: begin
                if (space) begin
                    issue = 1'b1;
                    if (rd_frame_last) state_d = rd_chan_last ? RD_RELEASE : RD_SCAN;
                end
            end
            RD_RELEASE: begin
                release_bank = 1'b1;
                state_d      = RD_IDLE;
            end
            default:    state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            rd_bank   <= 1'b0;
            rd_chan   <= '0;
            rd_frame  <= '0;
            mask_q    <= '0;
            rd_pend   <= 1'b0;
            pend_last <= 1'b0;
            pend_chan <= '0;
        end else begin
            rd_pend <= issue;
            if (issue) begin
                pend_last <= rd_frame_last;
                pend_chan <= rd_chan;
            end
            case (state)
                RD_IDLE: begin
                    if (full[rd_bank]) begin
                        mask_q  <= mask;
                        rd_chan <= '0;
                    end
                end
                RD_SCAN: begin
                    if (mask_q[rd_chan])    rd_frame <= '0;
                    else if (!rd_chan_last) rd_chan  <= rd_chan + CHAN_W'(1);
                end
                RD_READ: begin
                    if (issue) begin
                        rd_frame <= rd_frame + FRAME_W'(1);
                        if (rd_frame_last && !rd_chan_last) rd_chan <= rd_chan + CHAN_W'(1);
                    end
                end
                RD_RELEASE: rd_bank <= ~rd_bank;
                default: ;
            endcase
        end
    end

    // Two-entry output skid; sk0 is always the head.
    assign push_beat = '{data: ram_rdata, last: pend_last, chan: pend_chan};

    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            sk_cnt <= '0;
            sk0    <= '0;
            sk1    <= '0;
        end else begin
            case ({rd_pend, pop})
                2'b10: begin
                    if (sk_cnt == 2'd0) sk0 <= push_beat;
                    else                sk1 <= push_beat;
                    sk_cnt <= sk_cnt + 2'd1;
                end
                2'b01: begin
                    sk0    <= sk1;
                    sk_cnt <= sk_cnt - 2'd1;
                end
                2'b11: begin
                    if (sk_cnt == 2'd1) sk0 <= push_beat;
                    else begin
                        sk0 <= sk1;
                        sk1 <= push_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axis.tvalid = (sk_cnt != 2'd0);
    assign m_axis.tdata  = sk0.data;
    assign m_axis.tlast  = sk0.last;
    assign m_chan        = sk0.chan;

endmodule

// File: tb/tb_chan_demux.sv
// Directed bench for chan_demux (4 channels, 2-frame packets) with an
// expected-beat queue filled as banks are sent and drained by an output monitor.
`timescale 1ns/1ps
module tb_chan_demux;
    import chan_demux_pkg::*;

    localparam int NUM_CHANS = 4;
    localparam int PKT_LEN   = 2;
    localparam int SR_BASE   = 128;
    localparam int CHAN_W    = 2;

    typedef struct packed {
        logic [31:0]       data;
        logic              last;
        logic [CHAN_W-1:0] chan;
    } exp_t;

    logic              ce_clk = 1'b0;
    logic              ce_rst = 1'b1;
    logic              set_stb = 1'b0;
    logic [7:0]        set_addr = '0;
    logic [31:0]       set_data = '0;
    logic [CHAN_W-1:0] m_chan;
    logic              sync_err;

    chan_demux_if #(.DATA_W(32)) s_axis ();
    chan_demux_if #(.DATA_W(32)) m_axis ();

    chan_demux #(.NUM_CHANS(NUM_CHANS), .PKT_LEN(PKT_LEN), .SR_BASE(SR_BASE)) dut (
        .ce_clk   (ce_clk),
        .ce_rst   (ce_rst),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .s_axis   (s_axis),
        .m_axis   (m_axis),
        .m_chan   (m_chan),
        .sync_err (sync_err)
    );

    always #5 ce_clk = ~ce_clk;

    int   checks = 0;
    int   errors = 0;
    int   sync_cnt = 0;
    int   tready_mode = 1;   // 0 stall, 1 always ready, 2 random 30% stalls
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_clk();
        @(posedge ce_clk);
        #1;
    endtask

    task automatic sr_write(input logic [7:0] addr, input logic [31:0] data);
        set_stb = 1'b1; set_addr = addr; set_data = data;
        wait_clk();
        set_stb = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int   n;
        logic ok;
        n = 0;
        s_axis.tvalid = 1'b1; s_axis.tdata = d; s_axis.tlast = l;
        do begin
            @(negedge ce_clk);
            ok = s_axis.tready;
            wait_clk();
            n++;
        end while (!ok && n < 3000);
        check("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic expect_bank(input logic [31:0] base, input logic [3:0] mask);
        for (int c = 0; c < NUM_CHANS; c++)
            if (mask[c])
                for (int f = 0; f < PKT_LEN; f++)
                    exp_q.push_back('{data: base + 32'(f * NUM_CHANS + c),
                                      last: (f == PKT_LEN - 1), chan: CHAN_W'(c)});
    endtask

    task automatic send_bank(input logic [31:0] base, input logic [3:0] mask);
        for (int i = 0; i < NUM_CHANS * PKT_LEN; i++)
            send_beat(base + 32'(i), (i % NUM_CHANS) == NUM_CHANS - 1);
        s_axis.tvalid = 1'b0;
        expect_bank(base, mask);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis.tvalid) && n < 2000) begin
            wait_clk();
            n++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_tvalid(input string tag);
        int   n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge ce_clk);
            seen = m_axis.tvalid;
            wait_clk();
            n++;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    // Consumer ready driver.
    initial begin
        m_axis.tready = 1'b1;
        forever begin
            wait_clk();
            case (tready_mode)
                0:       m_axis.tready = 1'b0;
                2:       m_axis.tready = ($urandom_range(0, 99) >= 30);
                default: m_axis.tready = 1'b1;
            endcase
        end
    end

    // Output monitor and scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge ce_clk);
            if (!ce_rst && sync_err) sync_cnt++;
            if (!ce_rst && m_axis.tvalid && m_axis.tready) begin
                check("out_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", m_axis.tdata, e.data);
                    check("out_last", 32'(m_axis.tlast), 32'(e.last));
                    check("out_chan", 32'(m_chan), 32'(e.chan));
                end
            end
        end
    end

    initial begin
        int sync_base;
        s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0;

        // Reset state
        ce_rst = 1'b1;
        repeat (3) wait_clk();
        @(negedge ce_clk);
        check("rst_s_tready", 32'(s_axis.tready), 32'd0);
        check("rst_m_tvalid", 32'(m_axis.tvalid), 32'd0);
        check("rst_m_tdata",  m_axis.tdata, 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        wait_clk();
        ce_rst = 1'b0;
        wait_clk();
        @(negedge ce_clk);
        check("post_rst_s_tready", 32'(s_axis.tready), 32'd1);
        wait_clk();

        // 1: full mask
        sr_write(8'(SR_BASE), 32'h0000_000F);
        send_bank(32'd0, 4'hF);
        drain();

        // 2: mask 0x5 (upper bits ignored, high word does not disturb low word)
        sr_write(8'(SR_BASE), 32'hFFFF_FFF5);
        sr_write(8'(SR_BASE + 1), 32'h0000_0000);
        send_bank(32'd16, 4'h5);
        send_bank(32'd32, 4'h5);
        drain();

        // 3: both banks fill under backpressure, then random stalls
        tready_mode = 0;
        sr_write(8'(SR_BASE), 32'h0000_000F);
        send_bank(32'd48, 4'hF);
        send_bank(32'd56, 4'hF);
        @(negedge ce_clk);
        check("both_full_s_tready", 32'(s_axis.tready), 32'd0);
        wait_clk();
        tready_mode = 2;
        send_bank(32'd64, 4'hF);
        drain();

        // 4: early tlast, then missing tlast, each discards the partial bank
        tready_mode = 1;
        sync_base = sync_cnt;
        send_beat(32'd80, 1'b0);
        send_beat(32'd81, 1'b0);
        send_beat(32'd82, 1'b1);
        s_axis.tvalid = 1'b0;
        repeat (3) wait_clk();
        check("sync_err_early", 32'(sync_cnt - sync_base), 32'd1);
        send_bank(32'd90, 4'hF);
        drain();
        sync_base = sync_cnt;
        for (int i = 0; i < NUM_CHANS; i++) send_beat(32'd100 + 32'(i), 1'b0);
        s_axis.tvalid = 1'b0;
        repeat (3) wait_clk();
        check("sync_err_missing", 32'(sync_cnt - sync_base), 32'd1);
        send_bank(32'd110, 4'hF);
        drain();

        // 5: mask write during readout applies to the next bank only
        send_bank(32'd120, 4'hF);
        wait_tvalid("bank_a_output");
        sr_write(8'(SR_BASE), 32'h0000_0001);
        send_bank(32'd130, 4'h1);
        drain();

        // 6: reset mid-packet, then repeat test 1 with the reset mask
        sr_write(8'(SR_BASE), 32'h0000_000F);
        send_bank(32'd200, 4'hF);
        wait_tvalid("pre_rst_output");
        ce_rst = 1'b1;
        wait_clk();
        ce_rst = 1'b0;
        exp_q.delete();
        @(negedge ce_clk);
        check("mid_rst_m_tvalid", 32'(m_axis.tvalid), 32'd0);
        check("mid_rst_s_tready", 32'(s_axis.tready), 32'd0);
        wait_clk();
        @(negedge ce_clk);
        check("mid_rst_s_tready_after", 32'(s_axis.tready), 32'd1);
        wait_clk();
        send_bank(32'd0, 4'hF);
        drain();

        // All-zero mask consumes banks silently while input keeps flowing
        sr_write(8'(SR_BASE), 32'h0000_0000);
        send_bank(32'd300, 4'h0);
        send_bank(32'd310, 4'h0);
        send_bank(32'd320, 4'h0);
        repeat (20) wait_clk();
        @(negedge ce_clk);
        check("mask0_s_tready", 32'(s_axis.tready), 32'd1);
        check("mask0_m_tvalid", 32'(m_axis.tvalid), 32'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
